// File: rtl/iso14443_2a_pkg.sv
// rtl/iso14443_2a_pkg.sv - shared ISO/IEC 14443-2 Type A timing constants and demod state type
package iso14443_2a_pkg;

  localparam int SUBCARRIER_PERIOD = 16;
  localparam int BIT_TICKS         = 128;
  localparam int HALF_BIT_TICKS    = BIT_TICKS / 2;
  localparam int EDGE_THRESHOLD    = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOF_BIT  = 2'd1,
    ST_DATA_BIT = 2'd2
  } demod_state_e;

endpackage

// File: rtl/subcarrier_demod_if.sv
// rtl/subcarrier_demod_if.sv - enable, load-modulation input and decoded-event strobes
interface subcarrier_demod_if;

  logic en;
  logic lm_in;
  logic sof;
  logic data;
  logic data_valid;
  logic eof;
  logic error;

  modport master (
    output en, lm_in,
    input  sof, data, data_valid, eof, error
  );

  modport slave (
    input  en, lm_in,
    output sof, data, data_valid, eof, error
  );

endinterface

// File: rtl/subcarrier_detect.sv
// rtl/subcarrier_detect.sv - rising-edge counting per half-bit with a free-running bit tick
module subcarrier_detect
  import iso14443_2a_pkg::*;
#(
  parameter int HALF_TICKS = HALF_BIT_TICKS,
  parameter int THRESHOLD  = EDGE_THRESHOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lm_i,
  input  logic run_i,
  input  logic arm_i,
  output logic edge_o,
  output logic bit_done_o,
  output logic half_a_present_o,
  output logic half_b_present_o
);

  localparam int                TICK_W    = $clog2(2 * HALF_TICKS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(2 * HALF_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(HALF_TICKS);
  localparam logic [2:0]        THR       = 3'(THRESHOLD);

  logic              lm_prev_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [2:0]        cnt_a_acc, cnt_b_acc;
  logic              edge_w;

  assign edge_w = lm_i & ~lm_prev_q;
  assign edge_o = edge_w;

  always_comb begin
    cnt_a_acc = cnt_a_q;
    cnt_b_acc = cnt_b_q;
    // The current cycle's edge is folded in so the tick-127 decision sees it.
    if (edge_w) begin
      if (tick_q < HALF_TICK) begin
        if (cnt_a_q != 3'd7) cnt_a_acc = cnt_a_q + 3'd1;
      end else begin
        if (cnt_b_q != 3'd7) cnt_b_acc = cnt_b_q + 3'd1;
      end
    end
    bit_done_o       = run_i & (tick_q == LAST_TICK);
    half_a_present_o = cnt_a_acc >= THR;
    half_b_present_o = cnt_b_acc >= THR;
    tick_d  = '0;
    cnt_a_d = '0;
    cnt_b_d = '0;
    // Idle keeps tick at 0, so a start edge lands in the first half as tick 0.
    if ((run_i && !bit_done_o) || (arm_i && edge_w)) begin
      tick_d  = tick_q + TICK_W'(1);
      cnt_a_d = cnt_a_acc;
      cnt_b_d = cnt_b_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_prev_q <= 1'b0;
      tick_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      lm_prev_q <= lm_i;
      tick_q    <= tick_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

endmodule

// File: rtl/subcarrier_demod.sv
// rtl/subcarrier_demod.sv - Type A PICC-to-PCD Manchester subcarrier demodulator
module subcarrier_demod
  import iso14443_2a_pkg::*;
#(
  parameter int HALF_BIT_TICKS = iso14443_2a_pkg::HALF_BIT_TICKS,
  parameter int EDGE_THRESHOLD = iso14443_2a_pkg::EDGE_THRESHOLD
) (
  input logic               clk,
  input logic               rst_n,
  subcarrier_demod_if.slave bus
);

  demod_state_e state_q;
  logic sof_q, data_q, data_valid_q, eof_q, error_q;
  logic edge_w, bit_done_w, a_w, b_w;
  logic run_w, arm_w;

  assign run_w = bus.en & (state_q != ST_IDLE);
  assign arm_w = bus.en & (state_q == ST_IDLE);

  subcarrier_detect #(
    .HALF_TICKS (HALF_BIT_TICKS),
    .THRESHOLD  (EDGE_THRESHOLD)
  ) u_detect (
    .clk              (clk),
    .rst_n            (rst_n),
    .lm_i             (bus.lm_in),
    .run_i            (run_w),
    .arm_i            (arm_w),
    .edge_o           (edge_w),
    .bit_done_o       (bit_done_w),
    .half_a_present_o (a_w),
    .half_b_present_o (b_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sof_q        <= 1'b0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      eof_q        <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sof_q        <= 1'b0;
      data_valid_q <= 1'b0;
      eof_q        <= 1'b0;
      error_q      <= 1'b0;
      if (!bus.en) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (edge_w) state_q <= ST_SOF_BIT;
          end
          ST_SOF_BIT: begin
            // A lone '0' or empty first bit is treated as noise and dropped quietly.
            if (bit_done_w) begin
              if (a_w && b_w) begin
                error_q <= 1'b1;
                state_q <= ST_IDLE;
              end else if (a_w) begin
                sof_q   <= 1'b1;
                state_q <= ST_DATA_BIT;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DATA_BIT: begin
            if (bit_done_w) begin
              if (a_w && b_w) begin
                error_q <= 1'b1;
                state_q <= ST_IDLE;
              end else if (a_w || b_w) begin
                data_valid_q <= 1'b1;
                data_q       <= a_w;
              end else begin
                eof_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sof        = sof_q;
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.eof        = eof_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_subcarrier_demod.sv
// tb/tb_subcarrier_demod.sv - directed frame vectors for subcarrier_demod
module tb_subcarrier_demod;
  import iso14443_2a_pkg::*;

  localparam int K_SOF = 1;
  localparam int K_D0  = 2;
  localparam int K_D1  = 3;
  localparam int K_EOF = 4;
  localparam int K_ERR = 5;

  // bits: byte j = {periods in half A, periods in half B} of bit j
  // ev:   nibble j = event kind expected 128*(j+1) clocks after the first edge
  typedef struct {
    string       name;
    int          nbits;
    logic [63:0] bits;
    logic [31:0] ev;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mon_n;
  int   ev_k[$];
  int   ev_c[$];
  vec_t vecs[10];
  vec_t vdrop;

  subcarrier_demod_if bus();

  subcarrier_demod dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_outputs_zero",
            int'({bus.sof, bus.data_valid, bus.eof, bus.error}), 0);
    end else begin
      mon_n = int'(bus.sof) + int'(bus.data_valid) + int'(bus.eof) + int'(bus.error);
      if (mon_n > 0) begin
        check("one_pulse_per_cycle", int'(mon_n > 1), 0);
        if (bus.sof)        begin ev_k.push_back(K_SOF); ev_c.push_back(cyc); end
        if (bus.data_valid) begin ev_k.push_back(bus.data ? K_D1 : K_D0); ev_c.push_back(cyc); end
        if (bus.eof)        begin ev_k.push_back(K_EOF); ev_c.push_back(cyc); end
        if (bus.error)      begin ev_k.push_back(K_ERR); ev_c.push_back(cyc); end
      end
    end
  end

  function automatic logic sample_at(input logic [7:0] hb, input int i);
    int k;
    int j;
    k = (i < 64) ? int'(hb[7:4]) : int'(hb[3:0]);
    j = i % 64;
    return ((j / SUBCARRIER_PERIOD) < k) && ((j % SUBCARRIER_PERIOD) < 8);
  endfunction

  function automatic vec_t mk(input string name, input int nbits,
                              input logic [63:0] bits, input logic [31:0] ev);
    vec_t v;
    v.name  = name;
    v.nbits = nbits;
    v.bits  = bits;
    v.ev    = ev;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int drop_at);
    int start;
    int s;
    int k;
    int exp_k[$];
    int exp_c[$];
    ev_k.delete();
    ev_c.delete();
    s = 0;
    start = 0;
    for (int b = 0; b < v.nbits; b++) begin
      for (int i = 0; i < 2 * HALF_BIT_TICKS; i++) begin
        @(negedge clk);
        if (s == 0) start = cyc;
        bus.lm_in = sample_at(v.bits[8*b +: 8], i);
        if (s == drop_at) bus.en = 1'b0;
        s++;
      end
    end
    @(negedge clk);
    bus.lm_in = 1'b0;
    repeat (300) @(negedge clk);
    #2;
    for (int j = 0; j < 8; j++) begin
      k = int'(v.ev[4*j +: 4]);
      if (k != 0) begin
        exp_k.push_back(k);
        exp_c.push_back(BIT_TICKS * (j + 1));
      end
    end
    check({v.name, "_event_count"}, ev_k.size(), exp_k.size());
    for (int e = 0; e < exp_k.size(); e++) begin
      if (e < ev_k.size()) begin
        check($sformatf("%s_ev%0d_kind", v.name, e), ev_k[e], exp_k[e]);
        check($sformatf("%s_ev%0d_offset", v.name, e), ev_c[e] - start, exp_c[e]);
      end
    end
    check({v.name, "_back_to_idle"}, int'(dut.state_q), int'(ST_IDLE));
    bus.en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    vecs[0] = mk("ideal",     6, 64'h00_40_40_04_40_40, 32'h4_3_3_2_3_1);
    vecs[1] = mk("collision", 2, 64'h44_40,             32'h5_1);
    vecs[2] = mk("ideal_after_collision", 6, 64'h00_40_40_04_40_40, 32'h4_3_3_2_3_1);
    vecs[3] = mk("noise_pulse", 1, 64'h10,              32'h0);
    vecs[4] = mk("thresh3",   4, 64'h00_03_30_30,       32'h4_2_3_1);
    vecs[5] = mk("thresh2",   2, 64'h20_40,             32'h4_1);
    vecs[6] = mk("sof_zero",  1, 64'h14,                32'h0);
    vecs[7] = mk("sof_both",  1, 64'h44,                32'h5);
    vecs[8] = mk("back2back", 6, 64'h00_04_40_00_40_40, 32'h4_2_1_4_3_1);
    vecs[9] = mk("ideal_last", 6, 64'h00_40_40_04_40_40, 32'h4_3_3_2_3_1);
    vdrop   = mk("en_drop",   5, 64'h00_40_04_40_40,    32'h2_3_1);

    bus.en = 1'b1;
    bus.lm_in = 1'b0;
    rst_n = 1'b0;
    ph = 12;
    repeat (5) begin
      @(negedge clk);
      bus.lm_in = (ph % SUBCARRIER_PERIOD) < 8;
      ph++;
    end
    @(negedge clk);
    ev_k.delete();
    ev_c.delete();
    rst_n = 1'b1;
    bus.lm_in = (ph % SUBCARRIER_PERIOD) < 8;
    ph++;
    repeat (127) begin
      @(negedge clk);
      bus.lm_in = (ph % SUBCARRIER_PERIOD) < 8;
      ph++;
    end
    #2;
    check("quiet_first_bit_after_reset", ev_k.size(), 0);
    rst_n = 1'b0;
    bus.lm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    #2;
    check("midframe_reset_silent", ev_k.size(), 0);
    check("idle_after_reset", int'(dut.state_q), int'(ST_IDLE));

    for (int n = 0; n < 10; n++) run_vec(vecs[n], -1);

    run_vec(vdrop, 3 * BIT_TICKS + BIT_TICKS - 1);
    run_vec(vecs[0], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
